// File: rtl/field_wr_pkg.sv
// -----------------------------------------------------------------------------
// field_wr_pkg
// Shared definitions for the field write arbiter:
//   - fw_state_e    : arbiter FSM states (FW_IDLE, FW_GRANT)
//   - OVERLAP_CNT_W : width of the saturating overlap counter
//   - MERGE_W       : working width of masked_merge (upper bound on REG_W)
//   - masked_merge  : bitwise read-modify-write, (old & ~mask) | (data & mask)
// -----------------------------------------------------------------------------
package field_wr_pkg;

    localparam int OVERLAP_CNT_W = 8;

    // masked_merge works on a fixed wide word; callers zero-extend their
    // operands and truncate the result back to their register width.
    localparam int MERGE_W = 64;

    typedef enum logic [0:0] {
        FW_IDLE  = 1'b0,
        FW_GRANT = 1'b1
    } fw_state_e;

    // Pure bitwise merge: bits with mask=1 take data, the rest keep old_val.
    function automatic logic [MERGE_W-1:0] masked_merge(
        input logic [MERGE_W-1:0] old_val,
        input logic [MERGE_W-1:0] data,
        input logic [MERGE_W-1:0] mask
    );
        return (old_val & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/field_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req upward from ptr, wrapping
// at NUM_REQ, and returns the first requester found.
// Ports:
//   req    in  NUM_REQ : request vector
//   ptr    in  PTR_W   : search start index (always < NUM_REQ)
//   onehot out NUM_REQ : one-hot of the selected requester (0 if none)
//   idx    out PTR_W   : index of the selected requester (0 if none)
//   any    out 1       : at least one request is present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ, so one subtraction is enough to wrap.
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = PTR_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/field_wr_arbiter.sv
// -----------------------------------------------------------------------------
// field_wr_arbiter
// Serializes masked slice writes from NUM_REQ requesters into one shared
// signed partial-field register, with round-robin arbitration.
//
// Handshake: a requester raises req[i] (level) and holds it; the arbiter
// answers with a registered one-hot gnt; on the following edge, if req[i] is
// still high, the masked write commits using wr_data/wr_mask sampled at that
// edge and ack[i] pulses for one cycle. A requester must drop req[i] in the
// cycle it sees ack[i]; dropping req[i] while granted aborts with no write.
//
// Parameters: NUM_REQ (2..8), REG_W, REG_LSB, RESET_VAL.
// Ports:
//   clock_0     in  1               : clock, rising edge
//   reset_n     in  1               : asynchronous active-low reset
//   req         in  NUM_REQ         : write requests
//   wr_data     in  NUM_REQ*REG_W   : lane i data at [i*REG_W +: REG_W]
//   wr_mask     in  NUM_REQ*REG_W   : lane i bit enables, same packing
//   gnt         out NUM_REQ         : registered one-hot grant
//   ack         out NUM_REQ         : one-cycle commit pulse
//   reg_q       out signed [REG_LSB+REG_W-1:REG_LSB] : register image
//   busy        out 1               : FSM is not idle (state debug view)
//   overlap_cnt out 8               : saturating count of overlapping-mask
//                                     arbitration cycles
// Build option: FIELD_WR_TRACE_EN adds simulation-only grant/commit/abort
// trace messages; the synthesized logic is the same either way.
// -----------------------------------------------------------------------------
module field_wr_arbiter
    import field_wr_pkg::*;
#(
    parameter int               NUM_REQ   = 2,
    parameter int               REG_W     = 3,
    parameter int               REG_LSB   = 26,
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic                               clock_0,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*REG_W-1:0]           wr_data,
    input  logic [NUM_REQ*REG_W-1:0]           wr_mask,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 ack,
    output logic signed [REG_LSB+REG_W-1:REG_LSB] reg_q,
    output logic                               busy,
    output logic [OVERLAP_CNT_W-1:0]           overlap_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    fw_state_e         state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [REG_W-1:0]  reg_img;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic               overlap;
    logic [REG_W-1:0]   sel_data;
    logic [REG_W-1:0]   sel_mask;
    logic [REG_W-1:0]   merged;
    logic [PTR_W-1:0]   next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Any pair of requesting lanes whose masks share a bit.
    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (req[i] && req[j] &&
                    (|(wr_mask[i*REG_W +: REG_W] & wr_mask[j*REG_W +: REG_W]))) begin
                    overlap = 1'b1;
                end
            end
        end
    end

    // Data/mask of the granted lane, taken live at the commit edge.
    always_comb begin
        sel_data = wr_data[gnt_idx*REG_W +: REG_W];
        sel_mask = wr_mask[gnt_idx*REG_W +: REG_W];
        merged   = REG_W'(masked_merge(MERGE_W'(reg_img), MERGE_W'(sel_data),
                                       MERGE_W'(sel_mask)));
        if (int'(gnt_idx) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock_0 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FW_IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            gnt         <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            reg_img     <= RESET_VAL;
            overlap_cnt <= '0;
        end else begin
            case (state)
                FW_IDLE: begin
                    ack <= '0;
                    if (pick_any) begin
                        gnt     <= pick_onehot;
                        gnt_idx <= pick_idx;
                        busy    <= 1'b1;
                        state   <= FW_GRANT;
                        if (overlap && (overlap_cnt != {OVERLAP_CNT_W{1'b1}})) begin
                            overlap_cnt <= overlap_cnt + OVERLAP_CNT_W'(1);
                        end
                    end
                end
                FW_GRANT: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= FW_IDLE;
                    if (req[gnt_idx]) begin
                        reg_img <= merged;
                        ack     <= gnt;
                        rr_ptr  <= next_ptr;
                    end
                    // Abort path: pointer, image and ack stay as they are.
                end
                default: begin
                    state <= FW_IDLE;
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_q = reg_img;

`ifdef FIELD_WR_TRACE_EN
    always @(posedge clock_0) begin
        if (reset_n) begin
            if (state == FW_IDLE && pick_any) begin
                $display("[%0t] field_wr_arbiter: grant %0d", $time, pick_idx);
            end else if (state == FW_GRANT && req[gnt_idx]) begin
                $display("[%0t] field_wr_arbiter: commit %0d mask=%b old=%b new=%b",
                         $time, gnt_idx, sel_mask, reg_img, merged);
            end else if (state == FW_GRANT) begin
                $display("[%0t] field_wr_arbiter: abort %0d", $time, gnt_idx);
            end
        end
    end
`endif

endmodule

// File: tb/tb_field_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_field_wr_arbiter
// Directed bench for field_wr_arbiter with NUM_REQ=2, REG_W=3, REG_LSB=26,
// RESET_VAL=0. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_field_wr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int REG_W   = 3;
  localparam int REG_LSB = 26;

  logic                            clock_0;
  logic                            reset_n;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*REG_W-1:0]        wr_data;
  logic [NUM_REQ*REG_W-1:0]        wr_mask;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              ack;
  logic signed [REG_LSB+REG_W-1:REG_LSB] reg_q;
  logic                            busy;
  logic [7:0]                      overlap_cnt;

  int checks = 0;
  int errors = 0;

  field_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REG_W     (REG_W),
    .REG_LSB   (REG_LSB),
    .RESET_VAL (3'b000)
  ) dut (
    .clock_0     (clock_0),
    .reset_n     (reset_n),
    .req         (req),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .gnt         (gnt),
    .ack         (ack),
    .reg_q       (reg_q),
    .busy        (busy),
    .overlap_cnt (overlap_cnt)
  );

  // clock / reset
  initial begin
    clock_0 = 1'b0;
    forever #5 clock_0 = ~clock_0;
  end

  // driver helpers
  task automatic step();
    @(posedge clock_0);
    #1;
  endtask

  task automatic set_lanes(input logic [2:0] d1, input logic [2:0] m1,
                           input logic [2:0] d0, input logic [2:0] m0);
    wr_data = {d1, d0};
    wr_mask = {m1, m0};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    wr_data = '0;
    wr_mask = '0;

    // Reset state
    step();
    step();
    check("rst_reg_q", 32'($unsigned(reg_q)), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovl", 32'(overlap_cnt), 32'h0);
    reset_n = 1'b1;

    // Single write: lane 0, data 101, mask 111
    set_lanes(3'b000, 3'b000, 3'b101, 3'b111);
    req = 2'b01;
    step();
    check("w1_gnt", 32'(gnt), 32'h1);
    check("w1_busy", 32'(busy), 32'h1);
    check("w1_ack_early", 32'(ack), 32'h0);
    step();
    check("w1_ack", 32'(ack), 32'h1);
    check("w1_reg_q", 32'($unsigned(reg_q)), 32'h5);
    check("w1_gnt_clr", 32'(gnt), 32'h0);
    req = 2'b00;
    step();
    check("w1_ack_pulse", 32'(ack), 32'h0);

    // Partial write: lane 1, data 010, mask 110 -> 011
    set_lanes(3'b010, 3'b110, 3'b000, 3'b000);
    req = 2'b10;
    step();
    check("w2_gnt", 32'(gnt), 32'h2);
    step();
    check("w2_ack", 32'(ack), 32'h2);
    check("w2_reg_q", 32'($unsigned(reg_q)), 32'h3);
    req = 2'b00;
    step();
    check("w2_ovl", 32'(overlap_cnt), 32'h0);

    // Fairness: both lanes, full masks; lane0 data 100, lane1 data 001
    set_lanes(3'b001, 3'b111, 3'b100, 3'b111);
    req = 2'b11;
    step();
    check("f1_gnt", 32'(gnt), 32'h1);
    check("f1_ovl", 32'(overlap_cnt), 32'h1);
    step();
    check("f1_ack", 32'(ack), 32'h1);
    check("f1_reg_q", 32'($unsigned(reg_q)), 32'h4);
    req = 2'b10;
    step();
    check("f2_gnt", 32'(gnt), 32'h2);
    req = 2'b11;
    step();
    check("f2_ack", 32'(ack), 32'h2);
    check("f2_reg_q", 32'($unsigned(reg_q)), 32'h1);
    req = 2'b01;
    step();
    check("f3_gnt", 32'(gnt), 32'h1);
    req = 2'b11;
    step();
    check("f3_ack", 32'(ack), 32'h1);
    check("f3_reg_q", 32'($unsigned(reg_q)), 32'h4);
    req = 2'b10;
    step();
    check("f4_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    step();
    check("f4_abort_ack", 32'(ack), 32'h0);
    check("f4_abort_reg_q", 32'($unsigned(reg_q)), 32'h4);
    check("f_ovl", 32'(overlap_cnt), 32'h1);
    // lane1 aborted: pointer stays at 1 from the last lane-0 commit
    set_lanes(3'b001, 3'b111, 3'b100, 3'b111);
    req = 2'b10;
    step();
    check("f5_gnt", 32'(gnt), 32'h2);
    step();
    check("f5_ack", 32'(ack), 32'h2);
    check("f5_reg_q", 32'($unsigned(reg_q)), 32'h1);
    req = 2'b00;
    step();

    // Abort: lane0 granted then dropped; pointer must stay at 0
    set_lanes(3'b000, 3'b000, 3'b111, 3'b111);
    req = 2'b01;
    step();
    check("ab_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    check("ab_ack", 32'(ack), 32'h0);
    check("ab_gnt_clr", 32'(gnt), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_reg_q", 32'($unsigned(reg_q)), 32'h1);
    // both request, masks share bit0 -> overlap counts; lane 0 wins from ptr 0
    set_lanes(3'b000, 3'b001, 3'b010, 3'b011);
    req = 2'b11;
    step();
    check("ab2_gnt", 32'(gnt), 32'h1);
    check("ab2_ovl", 32'(overlap_cnt), 32'h2);
    set_lanes(3'b000, 3'b001, 3'b010, 3'b010);
    step();
    check("ab2_ack", 32'(ack), 32'h1);
    check("ab2_reg_q", 32'($unsigned(reg_q)), 32'h3);
    req = 2'b10;
    step();
    check("ab3_gnt", 32'(gnt), 32'h2);
    step();
    check("ab3_ack", 32'(ack), 32'h2);
    check("ab3_reg_q", 32'($unsigned(reg_q)), 32'h2);
    req = 2'b00;
    step();

    // All-zero mask still commits and acks
    set_lanes(3'b000, 3'b000, 3'b111, 3'b000);
    req = 2'b01;
    step();
    check("zm_gnt", 32'(gnt), 32'h1);
    step();
    check("zm_ack", 32'(ack), 32'h1);
    check("zm_reg_q", 32'($unsigned(reg_q)), 32'h2);
    req = 2'b00;
    step();

    // Reset during GRANT: lane 1 granted, then reset before commit
    set_lanes(3'b101, 3'b111, 3'b000, 3'b000);
    req = 2'b10;
    step();
    check("rm_gnt", 32'(gnt), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_reg_q", 32'($unsigned(reg_q)), 32'h0);
    check("rm_gnt_clr", 32'(gnt), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_ovl", 32'(overlap_cnt), 32'h0);
    req = 2'b00;
    step();
    check("rm_ack", 32'(ack), 32'h0);
    check("rm_reg_hold", 32'($unsigned(reg_q)), 32'h0);
    reset_n = 1'b1;
    // pointer back to 0 after reset; disjoint masks -> no overlap count
    set_lanes(3'b010, 3'b010, 3'b001, 3'b001);
    req = 2'b11;
    step();
    check("pr_gnt", 32'(gnt), 32'h1);
    check("pr_ovl", 32'(overlap_cnt), 32'h0);
    step();
    check("pr_reg_q", 32'($unsigned(reg_q)), 32'h1);
    req = 2'b00;
    step();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
